// File: rtl/snake_pkg.sv
// Shared types and constants for the snake game controller.
package snake_pkg;

    typedef enum logic [1:0] {
        DIR_UP    = 2'b00,
        DIR_DOWN  = 2'b01,
        DIR_LEFT  = 2'b10,
        DIR_RIGHT = 2'b11
    } dir_t;

    // Encoding chosen so IDLE/PLAY/DEAD map straight onto the game_state port.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_PLAY = 2'b01,
        ST_DEAD = 2'b10,
        ST_MOVE = 2'b11
    } state_t;

    localparam logic [1:0] PIX_NONE = 2'b00;
    localparam logic [1:0] PIX_HEAD = 2'b01;
    localparam logic [1:0] PIX_BODY = 2'b10;
    localparam logic [1:0] PIX_WALL = 2'b11;

    localparam int GRID_W  = 40;
    localparam int GRID_H  = 30;
    localparam int START_X = 20;
    localparam int START_Y = 15;

    function automatic logic is_opposite(input dir_t a, input dir_t b);
        case (a)
            DIR_UP:    return b == DIR_DOWN;
            DIR_DOWN:  return b == DIR_UP;
            DIR_LEFT:  return b == DIR_RIGHT;
            default:   return b == DIR_LEFT;
        endcase
    endfunction

endpackage

// File: rtl/snake_tick.sv
// Move-rate timer: counts 0..TICK_DIV-1 while enabled, pulses wrap on the last count.
module snake_tick #(
    parameter int TICK_DIV = 12_500_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic wrap
);
    localparam int CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign wrap = en && (cnt_q == CNT_W'(TICK_DIV - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clr)
            cnt_d = '0;
        else if (en)
            cnt_d = wrap ? '0 : cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

endmodule

// File: rtl/snake_ctrl.sv
// Snake game controller: body state, move scheduling, collisions, apple eating, pixel query.
// state | meaning: IDLE wait for start; PLAY tick counting; MOVE one-cycle step; DEAD frozen until start
module snake_ctrl
    import snake_pkg::*;
#(
    parameter int TICK_DIV = 12_500_000,
    parameter int MAX_LEN  = 16,
    parameter int INIT_LEN = 3,
    parameter int GRID_W   = snake_pkg::GRID_W,
    parameter int GRID_H   = snake_pkg::GRID_H
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       key_up,
    input  logic       key_down,
    input  logic       key_left,
    input  logic       key_right,
    input  logic [9:0] x_pos,
    input  logic [9:0] y_pos,
    input  logic [5:0] apple_x,
    input  logic [4:0] apple_y,
    output logic [1:0] snake,
    output logic       apple_req,
    output logic [7:0] score,
    output logic [1:0] game_state
);
    localparam int LEN_W = $clog2(MAX_LEN + 1);

    state_t           state_q, state_d;
    dir_t             dir_q, dir_d, pend_q, pend_d, key_dir;
    logic [LEN_W-1:0] len_q, len_d, new_len;
    logic [7:0]       score_q, score_d;
    logic             apple_req_q, apple_req_d;
    logic [1:0]       pix_q, pix_d, game_state_q, game_state_d;
    logic [5:0]       seg_x_q [MAX_LEN];
    logic [5:0]       seg_x_d [MAX_LEN];
    logic [4:0]       seg_y_q [MAX_LEN];
    logic [4:0]       seg_y_d [MAX_LEN];
    logic [5:0]       nx, cell_x;
    logic [4:0]       ny, cell_y;
    logic             key_vld, wall_hit, self_hit, eat, grow, body_hit, tick_wrap;

    snake_tick #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .clr  (state_q != ST_PLAY),
        .en   (state_q == ST_PLAY),
        .wrap (tick_wrap)
    );

    always_comb begin
        state_d     = state_q;
        dir_d       = dir_q;
        pend_d      = pend_q;
        len_d       = len_q;
        score_d     = score_q;
        apple_req_d = 1'b0;
        seg_x_d     = seg_x_q;
        seg_y_d     = seg_y_q;

        key_vld = key_up | key_down | key_left | key_right;
        key_dir = key_up ? DIR_UP : key_down ? DIR_DOWN : key_left ? DIR_LEFT : DIR_RIGHT;
        if (state_q != ST_DEAD && key_vld && !is_opposite(key_dir, dir_q))
            pend_d = key_dir;

        nx = seg_x_q[0];
        ny = seg_y_q[0];
        case (pend_q)
            DIR_UP:   ny = seg_y_q[0] - 5'd1;
            DIR_DOWN: ny = seg_y_q[0] + 5'd1;
            DIR_LEFT: nx = seg_x_q[0] - 6'd1;
            default:  nx = seg_x_q[0] + 6'd1;
        endcase
        wall_hit = (nx == 6'd0) || (nx == 6'(GRID_W - 1)) || (ny == 5'd0) || (ny == 5'(GRID_H - 1));
        eat      = (nx == apple_x) && (ny == apple_y);
        grow     = eat && (len_q < LEN_W'(MAX_LEN));
        new_len  = grow ? len_q + LEN_W'(1) : len_q;

        // The tail normally vacates this step, so it only blocks the head when growing.
        self_hit = 1'b0;
        for (int i = 0; i < MAX_LEN; i++)
            if ((i < int'(len_q) - 1 || (grow && i == int'(len_q) - 1)) &&
                seg_x_q[i] == nx && seg_y_q[i] == ny)
                self_hit = 1'b1;

        case (state_q)
            ST_IDLE: if (start) state_d = ST_PLAY;
            ST_PLAY: if (tick_wrap) state_d = ST_MOVE;
            ST_MOVE: begin
                dir_d = pend_q;
                if (wall_hit || self_hit) begin
                    state_d = ST_DEAD;
                end else begin
                    state_d = ST_PLAY;
                    len_d   = new_len;
                    if (eat) begin
                        apple_req_d = 1'b1;
                        if (score_q != 8'hFF) score_d = score_q + 8'd1;
                    end
                    for (int i = 1; i < MAX_LEN; i++) begin
                        seg_x_d[i] = (i < int'(new_len)) ? seg_x_q[i-1] : 6'd0;
                        seg_y_d[i] = (i < int'(new_len)) ? seg_y_q[i-1] : 5'd0;
                    end
                    seg_x_d[0] = nx;
                    seg_y_d[0] = ny;
                end
            end
            default: if (start) begin
                state_d = ST_PLAY;
                dir_d   = DIR_RIGHT;
                pend_d  = DIR_RIGHT;
                len_d   = LEN_W'(INIT_LEN);
                score_d = 8'd0;
                for (int i = 0; i < MAX_LEN; i++) begin
                    seg_x_d[i] = (i < INIT_LEN) ? 6'(START_X - i) : 6'd0;
                    seg_y_d[i] = (i < INIT_LEN) ? 5'(START_Y) : 5'd0;
                end
            end
        endcase

        game_state_d = (state_d == ST_MOVE) ? 2'(ST_PLAY) : 2'(state_d);
    end

    always_comb begin
        cell_x   = x_pos[9:4];
        cell_y   = y_pos[8:4];
        body_hit = 1'b0;
        for (int i = 1; i < MAX_LEN; i++)
            if (i < int'(len_q) && seg_x_q[i] == cell_x && seg_y_q[i] == cell_y)
                body_hit = 1'b1;
        pix_d = PIX_NONE;
        if (x_pos >= 10'd640 || y_pos >= 10'd480)
            pix_d = PIX_NONE;
        else if (cell_x == 6'd0 || cell_x == 6'(GRID_W - 1) || cell_y == 5'd0 || cell_y == 5'(GRID_H - 1))
            pix_d = PIX_WALL;
        else if (cell_x == seg_x_q[0] && cell_y == seg_y_q[0])
            pix_d = PIX_HEAD;
        else if (body_hit)
            pix_d = PIX_BODY;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            dir_q        <= DIR_RIGHT;
            pend_q       <= DIR_RIGHT;
            len_q        <= LEN_W'(INIT_LEN);
            score_q      <= 8'd0;
            apple_req_q  <= 1'b0;
            pix_q        <= PIX_NONE;
            game_state_q <= 2'b00;
            for (int i = 0; i < MAX_LEN; i++) begin
                seg_x_q[i] <= (i < INIT_LEN) ? 6'(START_X - i) : 6'd0;
                seg_y_q[i] <= (i < INIT_LEN) ? 5'(START_Y) : 5'd0;
            end
        end else begin
            state_q      <= state_d;
            dir_q        <= dir_d;
            pend_q       <= pend_d;
            len_q        <= len_d;
            score_q      <= score_d;
            apple_req_q  <= apple_req_d;
            pix_q        <= pix_d;
            game_state_q <= game_state_d;
            seg_x_q      <= seg_x_d;
            seg_y_q      <= seg_y_d;
        end
    end

    assign snake      = pix_q;
    assign apple_req  = apple_req_q;
    assign score      = score_q;
    assign game_state = game_state_q;

endmodule

// File: tb/tb_snake_ctrl.sv
// Directed scoreboard bench for snake_ctrl with a fast move tick.
module tb_snake_ctrl;

    localparam int K_PIX = 0, K_GS = 1, K_SCORE = 2, K_REQ = 3;

    typedef struct {
        int    due;
        int    kind;
        int    exp;
        string name;
    } chk_t;

    logic       clk, rst, start, key_up, key_down, key_left, key_right;
    logic [9:0] x_pos, y_pos;
    logic [5:0] apple_x;
    logic [4:0] apple_y;
    logic [1:0] snake, game_state;
    logic       apple_req;
    logic [7:0] score;

    chk_t sb[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_err = 0;
    int   act;

    snake_ctrl #(.TICK_DIV(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .key_up     (key_up),
        .key_down   (key_down),
        .key_left   (key_left),
        .key_right  (key_right),
        .x_pos      (x_pos),
        .y_pos      (y_pos),
        .apple_x    (apple_x),
        .apple_y    (apple_y),
        .snake      (snake),
        .apple_req  (apple_req),
        .score      (score),
        .game_state (game_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL watchdog: cycle %0d reached, expected completion earlier", cyc);
        $fatal(1);
    end

    // Monitor: compares every queued expectation when its cycle comes up.
    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].due <= cyc) begin
                case (sb[i].kind)
                    K_PIX:   act = int'(snake);
                    K_GS:    act = int'(game_state);
                    K_SCORE: act = int'(score);
                    default: act = int'(apple_req);
                endcase
                n_checks++;
                if (sb[i].due < cyc) begin
                    n_err++;
                    $display("FAIL %s: check missed (due %0d, now %0d)", sb[i].name, sb[i].due, cyc);
                end else if (act != sb[i].exp) begin
                    n_err++;
                    $display("FAIL %s: got %0d expected %0d (cycle %0d)", sb[i].name, act, sb[i].exp, cyc);
                end
                sb.delete(i);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic at(input int c);
        while (cyc < c) tick();
    endtask

    task automatic push(input int lat, input int kind, input int exp, input string name);
        chk_t c;
        c.due  = cyc + lat;
        c.kind = kind;
        c.exp  = exp;
        c.name = name;
        sb.push_back(c);
    endtask

    task automatic probe(input int x, input int y, input int exp, input string name);
        x_pos = 10'(x);
        y_pos = 10'(y);
        push(1, K_PIX, exp, name);
        tick();
    endtask

    task automatic key(input logic u, input logic d, input logic l, input logic r);
        key_up = u; key_down = d; key_left = l; key_right = r;
        tick();
        key_up = 0; key_down = 0; key_left = 0; key_right = 0;
    endtask

    task automatic set_apple(input int ax, input int ay);
        apple_x = 6'(ax);
        apple_y = 5'(ay);
    endtask

    task automatic begin_game(input int ax, input int ay, output int t0);
        set_apple(ax, ay);
        rst = 1;
        tick();
        tick();
        rst = 0;
        start = 1;
        t0 = cyc;
        tick();
        start = 0;
    endtask

    initial begin
        int t0;
        rst = 1; start = 0;
        key_up = 0; key_down = 0; key_left = 0; key_right = 0;
        x_pos = 0; y_pos = 0;
        set_apple(5, 5);

        // reset state and IDLE pixel query
        tick();
        push(0, K_GS, 0, "rst_state");
        push(0, K_SCORE, 0, "rst_score");
        push(0, K_REQ, 0, "rst_apple_req");
        push(0, K_PIX, 0, "rst_pixel");
        tick();
        rst = 0;
        probe(320, 240, 1, "idle_head");
        probe(304, 240, 2, "idle_seg1");
        probe(288, 240, 2, "idle_seg2");
        probe(272, 240, 0, "idle_past_tail");
        probe(336, 240, 0, "idle_front");
        probe(0, 0, 3, "pix_corner_wall");
        probe(700, 100, 0, "pix_offscreen_x");
        probe(100, 500, 0, "pix_offscreen_y");

        // free run right, reversal drop, priority, turn sequence
        begin_game(5, 5, t0);
        push(0, K_GS, 1, "play_after_start");
        at(t0 + 3); start = 1; tick(); start = 0;
        at(t0 + 6);
        probe(336, 240, 1, "move1_head21");
        probe(320, 240, 2, "move1_body20");
        probe(288, 240, 0, "move1_tail_vacated");
        at(t0 + 11); probe(352, 240, 1, "move2_head22");
        at(t0 + 16); probe(368, 240, 1, "move3_head23");
        at(t0 + 17); key(0, 0, 1, 0);
        at(t0 + 21); probe(384, 240, 1, "reverse_dropped_head24");
        at(t0 + 22); key(1, 0, 0, 1);
        at(t0 + 26); probe(384, 224, 1, "priority_up_head");
        at(t0 + 27); key(0, 0, 1, 0);
        at(t0 + 31);
        probe(368, 224, 1, "turn_left_head");
        probe(384, 224, 2, "turn_left_body");
        push(0, K_GS, 1, "turns_still_play");

        // eat and grow, then wall death and restart
        begin_game(22, 15, t0);
        at(t0 + 10); push(0, K_REQ, 0, "req_low_in_move");
        at(t0 + 11);
        push(0, K_REQ, 1, "eat_apple_req");
        push(0, K_SCORE, 1, "eat_score");
        set_apple(5, 5);
        probe(304, 240, 2, "grow_tail_kept");
        push(0, K_REQ, 0, "apple_req_one_cycle");
        push(0, K_SCORE, 1, "score_held");
        probe(288, 240, 0, "grow_beyond_tail");
        at(t0 + 96);
        push(0, K_GS, 2, "wall_dead");
        push(0, K_REQ, 0, "wall_no_req");
        probe(608, 240, 1, "dead_head_frozen");
        probe(592, 240, 2, "dead_body_frozen");
        push(0, K_GS, 2, "dead_holds");
        push(0, K_SCORE, 1, "dead_score_kept");
        probe(560, 240, 2, "dead_tail_frozen");
        at(t0 + 100); start = 1; tick(); start = 0;
        push(0, K_GS, 1, "restart_play");
        push(0, K_SCORE, 0, "restart_score");
        probe(320, 240, 1, "restart_head");
        probe(608, 240, 0, "restart_old_head_gone");
        probe(288, 240, 2, "restart_tail");
        probe(272, 240, 0, "restart_len3");

        // len 4: turn back into the tail cell, which vacates
        begin_game(21, 15, t0);
        at(t0 + 6);
        push(0, K_REQ, 1, "len4_eat_req");
        set_apple(5, 5);
        at(t0 + 12); key(1, 0, 0, 0);
        at(t0 + 17); key(0, 0, 1, 0);
        at(t0 + 22); key(0, 1, 0, 0);
        at(t0 + 26);
        push(0, K_GS, 1, "tail_vacate_alive");
        probe(336, 240, 1, "tail_vacate_head");
        probe(336, 224, 2, "tail_vacate_body");

        // len 5: same path hits its own body
        begin_game(21, 15, t0);
        at(t0 + 6); set_apple(22, 15);
        at(t0 + 11);
        push(0, K_SCORE, 2, "len5_score");
        set_apple(5, 5);
        at(t0 + 12); key(1, 0, 0, 0);
        at(t0 + 17); key(0, 0, 1, 0);
        at(t0 + 22); key(0, 1, 0, 0);
        at(t0 + 26);
        push(0, K_GS, 2, "self_hit_dead");
        probe(336, 224, 1, "self_hit_head_frozen");
        probe(336, 240, 2, "self_hit_body_shown");

        // reset during an eating MOVE
        begin_game(21, 15, t0);
        at(t0 + 5); rst = 1; tick(); rst = 0;
        push(0, K_GS, 0, "rst_move_idle");
        push(0, K_REQ, 0, "rst_move_no_req");
        push(0, K_SCORE, 0, "rst_move_score");
        probe(320, 240, 1, "rst_move_head");
        probe(336, 240, 0, "rst_move_no_step");
        push(0, K_REQ, 0, "rst_move_req_later");

        repeat (4) tick();
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
